// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer: takes a trap request from the exception controller,
// saves the PC and STATUS, vectors fetch, and restores state on sret.
module trap_sequencer #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  VBASE_RST = 32'h0000_0100,
  parameter int                 VEC_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_signal,
  input  logic [2:0]        int_pend,
  input  logic [DATA_W-1:0] cur_pc,
  input  logic              pc_valid,
  input  logic              sret,
  input  logic              csr_we,
  input  logic [1:0]        csr_addr,
  input  logic [DATA_W-1:0] csr_wdata,
  output logic [7:0]        status,
  output logic [DATA_W-1:0] sepc,
  output logic [DATA_W-1:0] vbase,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              stall,
  output logic              int_ret,
  output logic              in_handler
);

  typedef enum logic [2:0] {IDLE, CAPTURE, VECTOR, HANDLER, RESTORE} state_t;

  localparam logic [DATA_W-1:0] VB_MASK = DATA_W'((1 << VEC_SHIFT) - 1);

  state_t     state;
  logic [2:0] cause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cause       <= '0;
      status      <= 8'h02;
      sepc        <= '0;
      vbase       <= VBASE_RST;
      pc_redirect <= 1'b0;
      redirect_pc <= '0;
      stall       <= 1'b0;
      int_ret     <= 1'b0;
      in_handler  <= 1'b0;
    end else begin
      pc_redirect <= 1'b0;
      int_ret     <= 1'b0;
      // Software writes go first so a same-edge hardware update below overrides them.
      if (csr_we) begin
        case (csr_addr)
          2'd0:    status <= csr_wdata[7:0];
          2'd1:    sepc   <= csr_wdata;
          2'd2:    vbase  <= csr_wdata & ~VB_MASK;
          default: ;
        endcase
      end
      case (state)
        IDLE: begin
          if (int_signal) begin
            cause      <= int_pend;
            state      <= CAPTURE;
            stall      <= 1'b1;
            in_handler <= 1'b1;
          end
        end
        CAPTURE: begin
          if (pc_valid) begin
            sepc        <= cur_pc;
            status      <= {status[7:3], status[1], 2'b01};
            state       <= VECTOR;
            pc_redirect <= 1'b1;
            redirect_pc <= vbase + (DATA_W'(cause) << VEC_SHIFT);
          end
        end
        VECTOR: begin
          state <= HANDLER;
          stall <= 1'b0;
        end
        HANDLER: begin
          // Nested traps are not supported: int_signal is ignored here.
          if (sret) begin
            state       <= RESTORE;
            pc_redirect <= 1'b1;
            redirect_pc <= sepc;
            stall       <= 1'b1;
            int_ret     <= 1'b1;
          end
        end
        RESTORE: begin
          status     <= {status[7:3], status[2], status[2], 1'b0};
          state      <= IDLE;
          stall      <= 1'b0;
          in_handler <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
